// File: rtl/calc_pkg.sv
// Shared encodings for the calculator keypad sequencer: FSM states,
// display-source codes, operand-save codes and key arbitration.
package calc_pkg;

  localparam logic [3:0] ST_CLEAR  = 4'd0;
  localparam logic [3:0] ST_ENTER1 = 4'd1;
  localparam logic [3:0] ST_OPSEL  = 4'd2;
  localparam logic [3:0] ST_ENTER2 = 4'd3;
  localparam logic [3:0] ST_EXEC   = 4'd4;
  localparam logic [3:0] ST_RESULT = 4'd5;
  localparam logic [3:0] ST_ERROR  = 4'd6;

  localparam logic [1:0] DISP_BLANK = 2'b00;
  localparam logic [1:0] DISP_SAVE1 = 2'b01;
  localparam logic [1:0] DISP_OPER  = 2'b10;
  localparam logic [1:0] DISP_SAVE2 = 2'b11;

  localparam logic [1:0] SAVE_NONE = 2'b00;
  localparam logic [1:0] SAVE_1    = 2'b01;
  localparam logic [1:0] SAVE_2    = 2'b11;

  typedef enum logic [2:0] {
    KEY_NONE,
    KEY_NUM,
    KEY_OP,
    KEY_EQ,
    KEY_CLR
  } key_e;

  // Only the highest-priority key of a cycle survives; the rest are dropped.
  function automatic key_e key_pick(input logic c, input logic eq,
                                    input logic op, input logic num);
    if (c)        return KEY_CLR;
    else if (eq)  return KEY_EQ;
    else if (op)  return KEY_OP;
    else if (num) return KEY_NUM;
    else          return KEY_NONE;
  endfunction

  function automatic logic st_valid(input logic [3:0] st);
    return (st <= ST_ERROR);
  endfunction

endpackage

// File: rtl/calc_digit_cnt.sv
// Per-operand digit counter: clear, load-1 for the first digit of an operand,
// increment for further digits, saturating at MAX_DIGITS.
module calc_digit_cnt #(
  parameter int MAX_DIGITS = 4,
  parameter int CNT_W      = $clog2(MAX_DIGITS + 1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clr_i,
  input  logic             load1_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             at_max_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DIGITS);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign at_max_o = (cnt_q == CNT_MAX);
  assign cnt_o    = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load1_i) begin
      cnt_d = CNT_W'(1);
    end else if (inc_i && !at_max_o) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/calc_ctrl_seq.sv
// Calculator keypad control sequencer: turns key pulses into registered
// operand/operator/ALU strobes and display selection.
//
// state  | meaning
// CLEAR  | registers zeroed, waiting for first digit
// ENTER1 | collecting digits of operand 1 (or a fresh number after result)
// OPSEL  | operator captured, may be replaced until a digit arrives
// ENTER2 | collecting digits of operand 2
// EXEC   | ALU running, counting wait cycles against the timeout
// RESULT | result shown in save1; eq repeats, op chains, num starts over
// ERROR  | ALU error or timeout; only C leaves
module calc_ctrl_seq
  import calc_pkg::*;
#(
  parameter int MAX_DIGITS  = 4,
  parameter int ALU_TIMEOUT = 16,
  localparam int CNT_W      = $clog2(MAX_DIGITS + 1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             num,
  input  logic             op,
  input  logic             eq,
  input  logic             C,
  input  logic             alu_done,
  input  logic             alu_err,
  output logic [1:0]       save_enable,
  output logic             op_enable,
  output logic             alu_start,
  output logic             equ_enable,
  output logic             clr_data,
  output logic [1:0]       disp_sel,
  output logic [CNT_W-1:0] digit_cnt,
  output logic             err,
  output logic [3:0]       curr_state
);

  localparam int TMO_W = $clog2(ALU_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ALU_TIMEOUT - 1);

  logic [3:0]       state_q, state_d;
  logic [1:0]       save_q, save_d;
  logic             op_en_q, op_en_d;
  logic             start_q, start_d;
  logic             equ_q, equ_d;
  logic             clr_q, clr_d;
  logic [1:0]       disp_q, disp_d;
  logic             err_q, err_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;

  logic             cnt_clr, cnt_load1, cnt_inc, cnt_at_max;
  key_e             key;

  calc_digit_cnt #(
    .MAX_DIGITS (MAX_DIGITS),
    .CNT_W      (CNT_W)
  ) u_digit_cnt (
    .clk      (clk),
    .resetn   (resetn),
    .clr_i    (cnt_clr),
    .load1_i  (cnt_load1),
    .inc_i    (cnt_inc),
    .cnt_o    (digit_cnt),
    .at_max_o (cnt_at_max)
  );

  always_comb begin
    key       = key_pick(C, eq, op, num);
    state_d   = state_q;
    save_d    = SAVE_NONE;
    op_en_d   = 1'b0;
    start_d   = 1'b0;
    equ_d     = 1'b0;
    clr_d     = 1'b0;
    tmo_d     = tmo_q;
    cnt_clr   = 1'b0;
    cnt_load1 = 1'b0;
    cnt_inc   = 1'b0;

    case (state_q)
      ST_CLEAR: begin
        if (key == KEY_NUM) begin
          state_d   = ST_ENTER1;
          save_d    = SAVE_1;
          cnt_load1 = 1'b1;
        end
      end
      ST_ENTER1: begin
        if (key == KEY_NUM && !cnt_at_max) begin
          save_d  = SAVE_1;
          cnt_inc = 1'b1;
        end else if (key == KEY_OP) begin
          state_d = ST_OPSEL;
          op_en_d = 1'b1;
          cnt_clr = 1'b1;
        end
      end
      ST_OPSEL: begin
        if (key == KEY_OP) begin
          op_en_d = 1'b1;
        end else if (key == KEY_NUM) begin
          state_d   = ST_ENTER2;
          save_d    = SAVE_2;
          cnt_load1 = 1'b1;
        end
      end
      ST_ENTER2: begin
        if (key == KEY_NUM && !cnt_at_max) begin
          save_d  = SAVE_2;
          cnt_inc = 1'b1;
        end else if (key == KEY_EQ) begin
          state_d = ST_EXEC;
          start_d = 1'b1;
          tmo_d   = '0;
        end
      end
      ST_EXEC: begin
        if (alu_done) begin
          state_d = alu_err ? ST_ERROR : ST_RESULT;
          equ_d   = !alu_err;
        end else if (tmo_q == TMO_LAST) begin
          state_d = ST_ERROR;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_RESULT: begin
        if (key == KEY_EQ) begin
          state_d = ST_EXEC;
          start_d = 1'b1;
          tmo_d   = '0;
        end else if (key == KEY_OP) begin
          state_d = ST_OPSEL;
          op_en_d = 1'b1;
          cnt_clr = 1'b1;
        end else if (key == KEY_NUM) begin
          // Starting a new number discards the previous result in one cycle.
          state_d   = ST_ENTER1;
          clr_d     = 1'b1;
          save_d    = SAVE_1;
          cnt_load1 = 1'b1;
        end
      end
      ST_ERROR: begin
      end
      default: begin
        state_d = ST_ERROR;
      end
    endcase

    if (key == KEY_CLR && st_valid(state_q)) begin
      state_d   = ST_CLEAR;
      save_d    = SAVE_NONE;
      op_en_d   = 1'b0;
      start_d   = 1'b0;
      equ_d     = 1'b0;
      clr_d     = 1'b1;
      cnt_clr   = 1'b1;
      cnt_load1 = 1'b0;
      cnt_inc   = 1'b0;
    end

    case (state_d)
      ST_ENTER1: disp_d = DISP_SAVE1;
      ST_OPSEL:  disp_d = DISP_OPER;
      ST_ENTER2: disp_d = DISP_SAVE2;
      ST_EXEC:   disp_d = disp_q;
      ST_RESULT: disp_d = DISP_SAVE1;
      default:   disp_d = DISP_BLANK;
    endcase
    err_d = (state_d == ST_ERROR);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_CLEAR;
      save_q  <= SAVE_NONE;
      op_en_q <= 1'b0;
      start_q <= 1'b0;
      equ_q   <= 1'b0;
      clr_q   <= 1'b0;
      disp_q  <= DISP_BLANK;
      err_q   <= 1'b0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      save_q  <= save_d;
      op_en_q <= op_en_d;
      start_q <= start_d;
      equ_q   <= equ_d;
      clr_q   <= clr_d;
      disp_q  <= disp_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
    end
  end

  assign curr_state  = state_q;
  assign save_enable = save_q;
  assign op_enable   = op_en_q;
  assign alu_start   = start_q;
  assign equ_enable  = equ_q;
  assign clr_data    = clr_q;
  assign disp_sel    = disp_q;
  assign err         = err_q;

endmodule

// File: tb/tb_calc_ctrl_seq.sv
// Bench for calc_ctrl_seq: vector table, directed multi-cycle corners and a
// randomized run against a behavioural model of the key rules.
module tb_calc_ctrl_seq;
  import calc_pkg::*;

  localparam int MAXD = 4;
  localparam int TMO  = 16;

  logic clk, resetn, num, op, eq, C, alu_done, alu_err;
  logic [1:0] save_enable, disp_sel;
  logic op_enable, alu_start, equ_enable, clr_data, err;
  logic [2:0] digit_cnt;
  logic [3:0] curr_state;

  calc_ctrl_seq #(.MAX_DIGITS(MAXD), .ALU_TIMEOUT(TMO)) dut (
    .clk(clk), .resetn(resetn), .num(num), .op(op), .eq(eq), .C(C),
    .alu_done(alu_done), .alu_err(alu_err), .save_enable(save_enable),
    .op_enable(op_enable), .alu_start(alu_start), .equ_enable(equ_enable),
    .clr_data(clr_data), .disp_sel(disp_sel), .digit_cnt(digit_cnt),
    .err(err), .curr_state(curr_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // keys packed as {C, eq, op, num, alu_done, alu_err}
  localparam logic [5:0] K_NONE = 6'b000000, K_NUM = 6'b000100, K_OP = 6'b001000,
                         K_EQ = 6'b010000, K_C = 6'b100000, K_DN = 6'b000010,
                         K_DNE = 6'b000011;

  typedef struct packed {
    logic [5:0]  keys;
    logic [15:0] exp;
    logic        cc;
  } vec_t;

  function automatic logic [15:0] pk(logic [3:0] st, logic [1:0] sv, logic [3:0] str,
                                     logic [1:0] dsp, logic [2:0] cnt, logic er);
    return {st, sv, str, dsp, cnt, er};
  endfunction

  function automatic vec_t v(logic [5:0] k, logic [3:0] st, logic [1:0] sv, logic [3:0] str,
                             logic [1:0] dsp, logic [2:0] cnt, logic er, logic cc);
    vec_t r;
    r.keys = k;
    r.exp  = pk(st, sv, str, dsp, cnt, er);
    r.cc   = cc;
    return r;
  endfunction

  function automatic logic [15:0] outs();
    return {curr_state, save_enable, op_enable, alu_start, equ_enable, clr_data,
            disp_sel, digit_cnt, err};
  endfunction

  task automatic chk(string name, logic [15:0] act, logic [15:0] exp, logic cnt_care);
    logic [15:0] m;
    m = cnt_care ? 16'hFFFF : 16'hFFF1;
    n_chk++;
    if ((act & m) === (exp & m)) n_pass++;
    else $display("FAIL %s: got %b want %b (mask %b)", name, act, exp, m);
  endtask

  task automatic chk_val(string name, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d", name, act, exp);
  endtask

  task automatic step(input logic [5:0] k);
    {C, eq, op, num, alu_done, alu_err} = k;
    @(posedge clk);
    #1;
    {C, eq, op, num, alu_done, alu_err} = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    #2;
    chk("reset_state", outs(), 16'h0000, 1'b1);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  // Behavioural reference: key rules applied to an abstract calculator state.
  typedef enum int {M_CLEAR, M_ENTER1, M_OPSEL, M_ENTER2, M_EXEC, M_RESULT, M_ERROR} mst_e;
  mst_e m_st;
  int   m_cnt, m_wait;
  logic m_known;
  logic [1:0] m_disp;
  logic [15:0] m_exp;

  function automatic logic [3:0] enc(mst_e s);
    case (s)
      M_CLEAR:  return ST_CLEAR;
      M_ENTER1: return ST_ENTER1;
      M_OPSEL:  return ST_OPSEL;
      M_ENTER2: return ST_ENTER2;
      M_EXEC:   return ST_EXEC;
      M_RESULT: return ST_RESULT;
      default:  return ST_ERROR;
    endcase
  endfunction

  task automatic model_reset();
    m_st = M_CLEAR; m_cnt = 0; m_wait = 0; m_known = 1'b1; m_disp = 2'b00;
  endtask

  task automatic model_step(input logic [5:0] k);
    logic [1:0] sv;
    logic ope, sta, equ, clr;
    string key;
    sv = 2'b00; ope = 0; sta = 0; equ = 0; clr = 0;
    key = k[5] ? "C" : k[4] ? "EQ" : k[3] ? "OP" : k[2] ? "NUM" : "";
    if (key == "C") begin
      m_st = M_CLEAR; clr = 1; m_cnt = 0; m_known = 1;
    end else begin
      case (m_st)
        M_CLEAR: if (key == "NUM") begin m_st = M_ENTER1; sv = 2'b01; m_cnt = 1; m_known = 1; end
        M_ENTER1, M_ENTER2: begin
          if (key == "NUM" && m_cnt < MAXD) begin
            sv = (m_st == M_ENTER1) ? 2'b01 : 2'b11;
            m_cnt = m_cnt + 1;
          end else if (key == "OP" && m_st == M_ENTER1) begin
            m_st = M_OPSEL; ope = 1; m_cnt = 0; m_known = 1;
          end else if (key == "EQ" && m_st == M_ENTER2) begin
            m_st = M_EXEC; sta = 1; m_wait = 0; m_known = 0;
          end
        end
        M_OPSEL: begin
          if (key == "OP") ope = 1;
          else if (key == "NUM") begin m_st = M_ENTER2; sv = 2'b11; m_cnt = 1; m_known = 1; end
        end
        M_EXEC: begin
          if (k[1]) begin
            if (k[0]) m_st = M_ERROR;
            else begin m_st = M_RESULT; equ = 1; end
          end else begin
            m_wait = m_wait + 1;
            if (m_wait >= TMO) m_st = M_ERROR;
          end
        end
        M_RESULT: begin
          if (key == "EQ") begin m_st = M_EXEC; sta = 1; m_wait = 0; end
          else if (key == "OP") begin m_st = M_OPSEL; ope = 1; m_known = 0; end
          else if (key == "NUM") begin
            m_st = M_ENTER1; clr = 1; sv = 2'b01; m_cnt = 1; m_known = 1;
          end
        end
        default: ;
      endcase
    end
    case (m_st)
      M_CLEAR, M_ERROR:     m_disp = 2'b00;
      M_ENTER1, M_RESULT:   m_disp = 2'b01;
      M_OPSEL:              m_disp = 2'b10;
      M_ENTER2:             m_disp = 2'b11;
      default:              ;
    endcase
    m_exp = {enc(m_st), sv, ope, sta, equ, clr, m_disp, 3'(m_cnt), logic'(m_st == M_ERROR)};
  endtask

  vec_t tbl[$];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int pulses;
    resetn = 1'b1;
    {C, eq, op, num, alu_done, alu_err} = '0;

    // Vector table: full sequence, repeat equals, ignored keys, simultaneous keys.
    tbl.push_back(v(K_NUM,       ST_ENTER1, 2'b01, 4'b0000, 2'b01, 1, 0, 1));
    tbl.push_back(v(K_OP,        ST_OPSEL,  2'b00, 4'b1000, 2'b10, 0, 0, 1));
    tbl.push_back(v(K_OP,        ST_OPSEL,  2'b00, 4'b1000, 2'b10, 0, 0, 1));
    tbl.push_back(v(K_NUM,       ST_ENTER2, 2'b11, 4'b0000, 2'b11, 1, 0, 1));
    tbl.push_back(v(K_EQ | K_OP, ST_EXEC,   2'b00, 4'b0100, 2'b11, 0, 0, 0));
    tbl.push_back(v(K_NONE,      ST_EXEC,   2'b00, 4'b0000, 2'b11, 0, 0, 0));
    tbl.push_back(v(K_NONE,      ST_EXEC,   2'b00, 4'b0000, 2'b11, 0, 0, 0));
    tbl.push_back(v(K_DN,        ST_RESULT, 2'b00, 4'b0010, 2'b01, 0, 0, 0));
    tbl.push_back(v(K_EQ,        ST_EXEC,   2'b00, 4'b0100, 2'b01, 0, 0, 0));
    tbl.push_back(v(K_DN,        ST_RESULT, 2'b00, 4'b0010, 2'b01, 0, 0, 0));
    tbl.push_back(v(K_EQ,        ST_EXEC,   2'b00, 4'b0100, 2'b01, 0, 0, 0));
    tbl.push_back(v(K_DN,        ST_RESULT, 2'b00, 4'b0010, 2'b01, 0, 0, 0));
    tbl.push_back(v(K_NUM,       ST_ENTER1, 2'b01, 4'b0001, 2'b01, 1, 0, 1));
    tbl.push_back(v(K_NUM,       ST_ENTER1, 2'b01, 4'b0000, 2'b01, 2, 0, 1));
    tbl.push_back(v(K_C | K_NUM, ST_CLEAR,  2'b00, 4'b0001, 2'b00, 0, 0, 1));
    tbl.push_back(v(K_OP,        ST_CLEAR,  2'b00, 4'b0000, 2'b00, 0, 0, 1));
    tbl.push_back(v(K_EQ,        ST_CLEAR,  2'b00, 4'b0000, 2'b00, 0, 0, 1));
    tbl.push_back(v(K_DN,        ST_CLEAR,  2'b00, 4'b0000, 2'b00, 0, 0, 1));
    tbl.push_back(v(K_NUM,       ST_ENTER1, 2'b01, 4'b0000, 2'b01, 1, 0, 1));
    tbl.push_back(v(K_EQ,        ST_ENTER1, 2'b00, 4'b0000, 2'b01, 1, 0, 1));
    tbl.push_back(v(K_OP | K_NUM,ST_OPSEL,  2'b00, 4'b1000, 2'b10, 0, 0, 1));
    tbl.push_back(v(K_EQ,        ST_OPSEL,  2'b00, 4'b0000, 2'b10, 0, 0, 1));
    tbl.push_back(v(K_NUM,       ST_ENTER2, 2'b11, 4'b0000, 2'b11, 1, 0, 1));
    tbl.push_back(v(K_OP,        ST_ENTER2, 2'b00, 4'b0000, 2'b11, 1, 0, 1));
    tbl.push_back(v(K_NUM,       ST_ENTER2, 2'b11, 4'b0000, 2'b11, 2, 0, 1));
    tbl.push_back(v(K_EQ,        ST_EXEC,   2'b00, 4'b0100, 2'b11, 0, 0, 0));
    tbl.push_back(v(K_DNE,       ST_ERROR,  2'b00, 4'b0000, 2'b00, 0, 1, 0));
    tbl.push_back(v(K_OP,        ST_ERROR,  2'b00, 4'b0000, 2'b00, 0, 1, 0));
    tbl.push_back(v(K_NUM,       ST_ERROR,  2'b00, 4'b0000, 2'b00, 0, 1, 0));
    tbl.push_back(v(K_EQ,        ST_ERROR,  2'b00, 4'b0000, 2'b00, 0, 1, 0));
    tbl.push_back(v(K_C,         ST_CLEAR,  2'b00, 4'b0001, 2'b00, 0, 0, 1));

    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].keys);
      chk($sformatf("vec%0d", i), outs(), tbl[i].exp, tbl[i].cc);
    end

    // Digit limit: six digits, only four accepted.
    do_reset();
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      step(K_NUM);
      if (save_enable == 2'b01) pulses++;
      chk_val($sformatf("digit_cnt_%0d", i), int'(digit_cnt), (i < MAXD) ? i + 1 : MAXD);
    end
    chk_val("digit_limit_pulses", pulses, MAXD);

    // Timeout with no alu_done.
    do_reset();
    step(K_NUM); step(K_OP); step(K_NUM); step(K_EQ);
    chk_val("tmo_start", int'(alu_start), 1);
    for (int i = 1; i < TMO; i++) begin
      step(K_NONE);
      if (i == TMO - 1) chk("tmo_before", outs(), pk(ST_EXEC, 2'b00, 4'b0000, 2'b11, 0, 0), 1'b0);
    end
    step(K_NONE);
    chk("tmo_expired", outs(), pk(ST_ERROR, 2'b00, 4'b0000, 2'b00, 0, 1), 1'b0);
    step(K_OP);
    chk("tmo_op_ign", outs(), pk(ST_ERROR, 2'b00, 4'b0000, 2'b00, 0, 1), 1'b0);
    step(K_NUM);
    chk("tmo_num_ign", outs(), pk(ST_ERROR, 2'b00, 4'b0000, 2'b00, 0, 1), 1'b0);
    step(K_C);
    chk("tmo_clear", outs(), pk(ST_CLEAR, 2'b00, 4'b0001, 2'b00, 0, 0), 1'b1);

    // Async reset in EXEC, then a stale alu_done.
    do_reset();
    step(K_NUM); step(K_OP); step(K_NUM); step(K_EQ); step(K_NONE);
    chk_val("arst_in_exec", int'(curr_state), int'(ST_EXEC));
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_immediate", outs(), 16'h0000, 1'b1);
    @(negedge clk);
    resetn = 1'b1;
    step(K_DN);
    chk("arst_stale_done", outs(), 16'h0000, 1'b1);

    // Randomized run against the reference model.
    do_reset();
    model_reset();
    for (int i = 0; i < 3000; i++) begin
      logic [5:0] k;
      k[5] = ($urandom_range(0, 99) < 3);
      k[4] = ($urandom_range(0, 99) < 15);
      k[3] = ($urandom_range(0, 99) < 20);
      k[2] = ($urandom_range(0, 99) < 35);
      k[1] = ($urandom_range(0, 7) == 0);
      k[0] = ($urandom_range(0, 3) == 0);
      model_step(k);
      step(k);
      chk($sformatf("rand%0d", i), outs(), m_exp, m_known);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/calc_ctrl_seq.md
CALC_CTRL_SEQ -- requirements
Module: calc_ctrl_seq

Interface
REQ-001 SHALL have parameter MAX_DIGITS, default 4: maximum digits accepted per operand.
REQ-002 SHALL have parameter ALU_TIMEOUT, default 16: maximum cycles to wait for alu_done before error.
REQ-003 SHALL have derived localparam CNT_W = clog2(MAX_DIGITS+1), the digit-counter width.
REQ-004 SHALL have ports, one per line:
- clk  in  1  system clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- num  in  1  digit key pressed; one-cycle pulse, debounced upstream.
- op  in  1  operator key pressed; one-cycle pulse.
- eq  in  1  equals key pressed; one-cycle pulse.
- C  in  1  clear key pressed; one-cycle pulse.
- alu_done  in  1  ALU result valid; one-cycle pulse.
- alu_err  in  1  ALU overflow or divide-by-zero; qualified by alu_done.
- save_enable  out  2  operand-register write strobe: 00 none, 01 save1, 11 save2.
- op_enable  out  1  operator-register write strobe.
- alu_start  out  1  ALU start strobe.
- equ_enable  out  1  write ALU result into save1.
- clr_data  out  1  zero the save1, save2 and operator registers.
- disp_sel  out  2  display source: 00 blank/0, 01 save1/result, 10 operator, 11 save2.
- digit_cnt  out  CNT_W  number of digits accepted for the current operand.
- err  out  1  error indicator.
- curr_state  out  4  current state, for debug.

Function
REQ-005 SHALL register all outputs; a response appears in the cycle after the clk edge that samples the key (latency 1); strobes SHALL be high for exactly one cycle.
REQ-006 SHALL resolve simultaneous keys with priority C > eq > op > num; lower-priority keys in that cycle are dropped.
REQ-007 SHALL implement states CLEAR, ENTER1, OPSEL, ENTER2, EXEC, RESULT, ERROR.
REQ-008 C in any state SHALL go to CLEAR and pulse clr_data; digit_cnt=0, err=0, disp_sel=00.
REQ-009 CLEAR SHALL do the following:
- num: go to ENTER1; save_enable=01; digit_cnt=1.
- op, eq: ignored.
REQ-010 ENTER1 (disp_sel=01) SHALL do the following:
- num with digit_cnt<MAX_DIGITS: save_enable=01; digit_cnt+1.
- num with digit_cnt==MAX_DIGITS: ignored, no strobe.
- op: go to OPSEL; op_enable; digit_cnt=0.
- eq: ignored.
REQ-011 OPSEL (disp_sel=10) SHALL do the following:
- op: op_enable again, replacing the operator.
- num: go to ENTER2; save_enable=11; digit_cnt=1.
- eq: ignored.
REQ-012 ENTER2 (disp_sel=11) SHALL do the following:
- num: as ENTER1, but with save_enable=11.
- eq: go to EXEC; alu_start.
- op: ignored.
REQ-013 EXEC SHALL do the following:
- Hold disp_sel and count wait cycles.
- alu_done with !alu_err: go to RESULT; equ_enable.
- alu_done with alu_err: go to ERROR.
- ALU_TIMEOUT cycles without alu_done: go to ERROR.
- num, op, eq: ignored.
REQ-014 RESULT (disp_sel=01) SHALL do the following:
- eq: go to EXEC; alu_start (repeat last operator with result and the retained save2).
- op: go to OPSEL; op_enable (chain from result).
- num: go to ENTER1; clr_data and save_enable=01 in the same cycle; digit_cnt=1.
REQ-015 ERROR SHALL hold err=1 and disp_sel=00, ignore every key except C, and assert no strobe.
REQ-016 An unreachable curr_state encoding SHALL go to ERROR on the next clk.
REQ-017 The timeout counter SHALL clear on every entry to EXEC and SHALL NOT wrap.

Reset
REQ-018 resetn=0 SHALL immediately force the following, regardless of clk:
- curr_state=CLEAR.
- All strobes 0.
- disp_sel=00, digit_cnt=0, err=0.
- Timeout counter 0.
REQ-019 Reset asserted during EXEC SHALL abandon the operation; a later alu_done SHALL be ignored because the state is no longer EXEC.

Structure
REQ-020 State encodings, disp_sel codes and save_enable codes SHALL live in shared package calc_pkg.
REQ-021 Digit counting (saturating at MAX_DIGITS, clear/load-1/increment) SHALL be sub-module calc_digit_cnt; the timeout counter stays inline.

Verification
REQ-022 Bench SHALL cover the following directed scenarios:
- Digit limit, MAX_DIGITS=4: num x6 from CLEAR -> exactly 4 save_enable=01 pulses; digit_cnt stays 4.
- Full sequence: num, op, op, num, eq, alu_done (alu_err=0) at +3 cycles -> op_enable x2, save_enable=11 x1, alu_start x1, equ_enable x1; final state RESULT.
- Repeat equals: in RESULT, eq x2 with alu_done each -> two alu_start and two equ_enable pulses; no save_enable.
- Timeout, ALU_TIMEOUT=16: eq in ENTER2, no alu_done -> err=1 after 16 cycles; op/num ignored; C -> CLEAR, clr_data pulse.
- Simultaneous keys: C+num in ENTER1 -> CLEAR and no save_enable; eq+op in ENTER2 -> alu_start only.
- Async reset: resetn low mid-EXEC, then alu_done -> outputs at reset values immediately; no equ_enable.
